// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with registered occupancy count, threshold flags and overflow/underflow pulses.
// FWFT selects between a registered read port and a head word that is visible before the pop.
module fifo_sync_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W+1)'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // Write while empty is never bypassed to the read side, so a simultaneous read is rejected.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - (ADDR_W+1)'(1);
            end
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is don't-care while empty; no gating needed.
            assign dout = mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: registered-read instance checked through a read-data scoreboard,
// plus a FWFT instance checked directly.
module tb_fifo_sync_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       wr_f, rd_f;
    logic [7:0] din_f;
    logic [7:0] dout_f;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [4:0] count_f;

    int errors = 0;
    int checks = 0;

    logic       exp_rd;
    logic [7:0] exp_q[$];
    logic       mon_want;
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    fifo_sync_param dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_param #(.FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
        .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one clock of stimulus from a negedge and returns at the following negedge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                         input logic acc_rd, input logic [7:0] exp_d);
        wr_en = w;
        din = d;
        rd_en = r;
        exp_rd = acc_rd;
        if (acc_rd) exp_q.push_back(exp_d);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_rd = 1'b0;
    endtask

    task automatic cycle_f(input logic w, input logic [7:0] d, input logic r);
        wr_f = w;
        din_f = d;
        rd_f = r;
        @(posedge clk);
        @(negedge clk);
        wr_f = 1'b0;
        rd_f = 1'b0;
    endtask

    // Scoreboard monitor: registered read data is valid shortly after the edge that accepted the read.
    always @(posedge clk) begin
        mon_want = exp_rd;
        #2;
        if (mon_want) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dout_order: read seen with no expected word, got %0h", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dout_order", {24'd0, dout}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_idx;
        int rd_idx;
        int cnt_pat[4];
        cnt_pat = '{2, 3, 2, 1};
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; din = 8'h00; exp_rd = 1'b0;
        wr_f = 1'b0; rd_f = 1'b0; din_f = 8'h00;

        @(negedge clk);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_almost_empty", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_almost_full", 32'(almost_full), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_almost_full", 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
            check("fill_full", 32'(full), (i + 1 == 16) ? 1 : 0);
            check("fill_almost_empty", 32'(almost_empty), (i + 1 <= 4) ? 1 : 0);
        end
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count_held", 32'(count), 16);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ovf_one_cycle", 32'(overflow), 0);

        // Drain 0x00..0x0F, then one read too many
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
            check("drain_count", 32'(count), 32'(15 - i));
            check("drain_almost_empty", 32'(almost_empty), (15 - i <= 4) ? 1 : 0);
        end
        check("drain_empty", 32'(empty), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check("unf_pulse", 32'(underflow), 1);
        check("unf_count", 32'(count), 0);
        check("unf_dout_held", 32'(dout), 32'h0F);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("unf_one_cycle", 32'(underflow), 0);

        // Simultaneous access at count 0, 8 and 16
        cycle(1'b1, 8'h50, 1'b1, 1'b0, 8'h00);
        check("sim0_count", 32'(count), 1);
        check("sim0_underflow", 32'(underflow), 1);
        check("sim0_overflow", 32'(overflow), 0);
        for (int i = 1; i < 8; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00);
        check("sim8_pre_count", 32'(count), 8);
        cycle(1'b1, 8'h58, 1'b1, 1'b1, 8'h50);
        check("sim8_count", 32'(count), 8);
        check("sim8_underflow", 32'(underflow), 0);
        check("sim8_overflow", 32'(overflow), 0);
        for (int i = 9; i < 17; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00);
        check("sim16_full", 32'(full), 1);
        cycle(1'b1, 8'h61, 1'b1, 1'b1, 8'h51);
        check("sim16_count", 32'(count), 15);
        check("sim16_overflow", 32'(overflow), 1);
        check("sim16_underflow", 32'(underflow), 0);
        for (int i = 2; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h50 + i));
        check("sim_drained", 32'(empty), 1);

        // Interleaved traffic across pointer wrap, occupancy 1..3
        cycle(1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
        wr_idx = 1;
        rd_idx = 0;
        for (int k = 0; k < 40; k++) begin
            if ((k % 4) < 2) begin
                cycle(1'b1, 8'(8'h80 + wr_idx), 1'b0, 1'b0, 8'h00);
                wr_idx++;
            end else begin
                cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h80 + rd_idx));
                rd_idx++;
            end
            check("wrap_count", 32'(count), 32'(cnt_pat[k % 4]));
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h80 + rd_idx));
        check("wrap_empty", 32'(empty), 1);

        // Reset mid-stream at count 9
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
        check("mid_count", 32'(count), 9);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_dout", 32'(dout), 0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h3C);
        check("mid_final_empty", 32'(empty), 1);

        // FWFT instance
        check("fwft_rst_empty", 32'(empty_f), 1);
        cycle_f(1'b1, 8'hA5, 1'b0);
        check("fwft_head", 32'(dout_f), 32'hA5);
        check("fwft_not_empty", 32'(empty_f), 0);
        cycle_f(1'b0, 8'h00, 1'b1);
        check("fwft_pop_empty", 32'(empty_f), 1);
        check("fwft_pop_count", 32'(count_f), 0);
        cycle_f(1'b1, 8'h11, 1'b0);
        cycle_f(1'b1, 8'h22, 1'b0);
        check("fwft_head2", 32'(dout_f), 32'h11);
        cycle_f(1'b0, 8'h00, 1'b1);
        check("fwft_next", 32'(dout_f), 32'h22);
        check("fwft_count", 32'(count_f), 1);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, pointer width, with DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter AF_LVL, default 12, almost-full threshold; legal range AE_LVL < AF_LVL <= DEPTH-1.
REQ-004 The block SHALL have parameter AE_LVL, default 4, almost-empty threshold; legal range 1 <= AE_LVL < AF_LVL.
REQ-005 The block SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-008 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-009 The block SHALL have port din, input, DATA_W bits, write data.
REQ-010 The block SHALL have port rd_en, input, 1 bit, read request (FWFT=1: pop/acknowledge of head word).
REQ-011 The block SHALL have port dout, output, DATA_W bits, read data.
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit, carrying the status flags.
REQ-013 The block SHALL have port count, output, ADDR_W+1 bits, current occupancy from 0 to DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, each an output of 1 bit, carrying error pulses.

Function
REQ-015 Storage SHALL be DEPTH x DATA_W, with ADDR_W-bit write and read pointers wrapping from DEPTH-1 to 0.
REQ-016 A write SHALL be accepted iff wr_en=1 and full=0: mem[wrptr] <= din and wrptr increments.
REQ-017 A read SHALL be accepted iff rd_en=1 and empty=0: rdptr increments.
REQ-018 count SHALL be a register updated each edge by +1 (write only), -1 (read only), or 0 (both or neither).
REQ-019 Flags SHALL decode combinationally from registered count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LVL), almost_empty = (count<=AE_LVL).
REQ-020 With both requests while not full and not empty, both SHALL be accepted and count SHALL stay unchanged.
REQ-021 With both requests while empty, only the write SHALL be accepted (no bypass), count SHALL go 0->1 and underflow SHALL pulse.
REQ-022 With both requests while full, only the read SHALL be accepted, count SHALL go DEPTH->DEPTH-1 and overflow SHALL pulse.
REQ-023 overflow SHALL be a registered one-cycle pulse, high in the cycle after any edge where wr_en=1 and full=1.
REQ-024 underflow SHALL be a registered one-cycle pulse, high in the cycle after any edge where rd_en=1 and empty=1.
REQ-025 A rejected request SHALL leave pointers, count, memory and dout unchanged.
REQ-026 With FWFT=0, dout SHALL be registered: it loads mem[rdptr] on an accepted read (valid the cycle after the rd_en edge) and holds otherwise.
REQ-027 With FWFT=0, a word written at edge N SHALL be readable from edge N+1, with empty=0 after edge N.
REQ-028 With FWFT=1, dout SHALL equal mem[rdptr] combinationally whenever empty=0, so the head word is visible before rd_en.
REQ-029 With FWFT=1, dout SHALL be don't-care while empty=1.
REQ-030 With FWFT=1, a word written at edge N into an empty FIFO SHALL appear on dout directly after edge N.
REQ-031 Write data SHALL be read back in exact write order across any number of pointer wraps.

Reset
REQ-032 While rst=1 at an edge, the block SHALL clear wrptr, rdptr and count to 0, clear registered dout, overflow and underflow to 0, and ignore wr_en and rd_en.
REQ-033 After reset, outputs SHALL be empty=1, almost_empty=1, full=0, almost_full=0 and count=0; memory contents are not cleared.
REQ-034 A reset asserted mid-operation SHALL discard all stored words, so that the first read after reset returns the first word written after reset.

Verification
REQ-035 Fill (defaults): write 16 words 0x00..0x0F -> almost_full=1 when count reaches 12, full=1 at count=16, and a 17th write pulses overflow with count held at 16.
REQ-036 Drain (defaults): read 16 words -> dout returns 0x00..0x0F in order one cycle after each rd_en, almost_empty=1 at count=4, then a further rd_en pulses underflow.
REQ-037 Wrap: perform 40 interleaved single writes and reads at count 1..3 -> order is preserved across pointer wrap and count never exceeds 3.
REQ-038 Simultaneous access: issue wr_en=rd_en=1 at count 0, at count 8 and at count 16 -> count becomes 1, stays 8, and becomes 15 respectively, with underflow and overflow pulses as specified.
REQ-039 FWFT=1: write 0xA5 into an empty FIFO -> dout=0xA5 the cycle after the write with no rd_en; rd_en then returns empty=1.
REQ-040 Reset: assert rst at count=9 mid-stream -> count=0 and empty=1 after the edge; write 0x3C then read -> dout=0x3C.
